// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and an external requester.
// The CPU has priority; a starvation counter and a bounded locked burst give the external side guaranteed access.
module dmem_arbiter #(
  parameter int W          = 32,
  parameter int AW         = 32,
  parameter int MAX_STARVE = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_mem_read,
  input  logic                              cpu_mem_write,
  input  logic [AW-1:0]                     cpu_addr,
  input  logic [W-1:0]                      cpu_wdata,
  output logic [W-1:0]                      cpu_rdata,
  output logic                              cpu_stall,
  input  logic                              ext_req,
  input  logic                              ext_we,
  input  logic                              ext_lock,
  input  logic [AW-1:0]                     ext_addr,
  input  logic [W-1:0]                      ext_wdata,
  output logic                              ext_gnt,
  output logic                              ext_rvalid,
  output logic [W-1:0]                      ext_rdata,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [AW-1:0]                     mem_addr,
  output logic [W-1:0]                      mem_wdata,
  input  logic [W-1:0]                      mem_rdata,
  output logic                              dbg_state,
  output logic [$clog2(MAX_STARVE+1)-1:0]   dbg_starve_cnt
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic            ext_rvalid_q, ext_rvalid_d;
  logic [W-1:0]    ext_rdata_q, ext_rdata_d;
  logic            cpu_act;

  // Handshake: ext_gnt is a same-cycle acknowledge; the access happens at the
  // edge ending a cycle with ext_gnt=1, and a granted read returns exactly one
  // ext_rvalid pulse in the following cycle with no back-pressure.
  always_comb begin
    cpu_act      = cpu_mem_read | cpu_mem_write;
    state_d      = state_q;
    starve_cnt_d = '0;
    burst_cnt_d  = burst_cnt_q;
    ext_rvalid_d = 1'b0;
    ext_rdata_d  = ext_rdata_q;
    ext_gnt      = 1'b0;

    if (state_q == ARB) begin
      ext_gnt = rst & ext_req & (~cpu_act | (starve_cnt_q == SW'(MAX_STARVE)));
      if (ext_gnt & ext_lock) begin
        state_d     = BURST;
        burst_cnt_d = BW'(1);
      end
      if (ext_req & ~ext_gnt)
        starve_cnt_d = (starve_cnt_q == SW'(MAX_STARVE)) ? starve_cnt_q : starve_cnt_q + SW'(1);
    end else begin
      ext_gnt = rst & ext_req & ext_lock & (burst_cnt_q < BW'(MAX_BURST));
      if (ext_gnt) begin
        burst_cnt_d = burst_cnt_q + BW'(1);
      end else begin
        state_d     = ARB;
        burst_cnt_d = '0;
      end
    end

    if (ext_gnt & ~ext_we) begin
      ext_rvalid_d = 1'b1;
      ext_rdata_d  = mem_rdata;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (ext_gnt) begin
        mem_read  = ext_req & ~ext_we;
        mem_write = ext_req & ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end else begin
        mem_read  = cpu_mem_read;
        mem_write = cpu_mem_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign cpu_rdata      = mem_rdata;
  assign cpu_stall      = cpu_act & ext_gnt;
  assign ext_rvalid     = ext_rvalid_q;
  assign ext_rdata      = ext_rdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// port-ownership reference model with its own copy of memory.
module tb_dmem_arbiter;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int MS = 4;
  localparam int MB = 4;
  localparam int SW = $clog2(MS + 1);

  logic clk = 1'b0, rst;
  logic cpu_mem_read, cpu_mem_write, cpu_stall;
  logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
  logic [W-1:0] cpu_wdata, cpu_rdata, ext_wdata, ext_rdata, mem_wdata, mem_rdata;
  logic ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid, mem_read, mem_write, dbg_state;
  logic [SW-1:0] dbg_starve_cnt;

  int checks = 0;
  int passes = 0;

  // data_memory stand-in: combinational read, write at the rising edge
  logic [W-1:0] ram [64];
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;

  // reference model state
  logic [W-1:0] ref_mem [64];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.W(W), .AW(AW), .MAX_STARVE(MS), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  task automatic idle_inputs();
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    cpu_mem_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h14; ext_wdata = 32'h2;
    #1;
    checks++; if (ext_gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", ext_gnt); else passes++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", cpu_stall); else passes++;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) $display("FAIL reset_mem_rw: got %b%b want 00", mem_read, mem_write); else passes++;
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); else passes++;
    @(negedge clk); #1;
    checks++; if (ext_rvalid !== 1'b0 || ext_rdata !== '0) $display("FAIL reset_rdata: got %b/%h want 0/0", ext_rvalid, ext_rdata); else passes++;
    checks++; if (dbg_state !== 1'b0 || dbg_starve_cnt !== '0) $display("FAIL reset_state: got %b/%0d want 0/0", dbg_state, dbg_starve_cnt); else passes++;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_cpu_alone();
    @(negedge clk);
    idle_inputs();
    cpu_mem_write = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL cpu_wr_arb: got gnt=%b stall=%b want 0/0", ext_gnt, cpu_stall); else passes++;
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF)
      $display("FAIL cpu_wr_bus: got we=%b %h/%h want 1 10/deadbeef", mem_write, mem_addr, mem_wdata); else passes++;
    @(negedge clk);
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b1;
    #1;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL cpu_rd_data: got %h want deadbeef", cpu_rdata); else passes++;
    checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_read !== 1'b1)
      $display("FAIL cpu_rd_arb: got gnt=%b stall=%b rd=%b want 0/0/1", ext_gnt, cpu_stall, mem_read); else passes++;
  endtask

  task automatic test_ext_idle_read();
    @(negedge clk);
    idle_inputs();
    ext_req = 1'b1; ext_addr = 32'h10;
    #1;
    checks++; if (ext_gnt !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h10)
      $display("FAIL ext_rd_gnt: got gnt=%b rd=%b addr=%h want 1/1/10", ext_gnt, mem_read, mem_addr); else passes++;
    @(negedge clk);
    ext_req = 1'b0;
    #1;
    checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'hDEADBEEF)
      $display("FAIL ext_rd_ret: got %b/%h want 1/deadbeef", ext_rvalid, ext_rdata); else passes++;
    @(negedge clk); #1;
    checks++; if (ext_rvalid !== 1'b0) $display("FAIL ext_rd_pulse: got %b want 0", ext_rvalid); else passes++;
  endtask

  task automatic test_starvation();
    bit exp_g;
    int exp_s;
    @(negedge clk);
    idle_inputs();
    cpu_mem_read = 1'b1; cpu_addr = 32'h10;
    ext_req = 1'b1; ext_addr = 32'h20;
    for (int c = 1; c <= 6; c++) begin
      #1;
      exp_g = (c == 5);
      exp_s = (c <= 5) ? c - 1 : 0;
      checks++; if (ext_gnt !== exp_g || cpu_stall !== exp_g)
        $display("FAIL starve_gnt c%0d: got gnt=%b stall=%b want %b", c, ext_gnt, cpu_stall, exp_g); else passes++;
      checks++; if (dbg_starve_cnt !== SW'(exp_s)) $display("FAIL starve_cnt c%0d: got %0d want %0d", c, dbg_starve_cnt, exp_s); else passes++;
      checks++; if (mem_addr !== (exp_g ? 32'h20 : 32'h10)) $display("FAIL starve_addr c%0d: got %h", c, mem_addr); else passes++;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_locked_burst();
    bit exp_g, exp_b;
    int k = 0;
    @(negedge clk);
    idle_inputs();
    cpu_mem_read = 1'b1; cpu_addr = 32'h10;
    ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1;
    ext_addr = 32'h20; ext_wdata = 32'hA000_0000;
    for (int c = 1; c <= 14; c++) begin
      #1;
      exp_g = (c >= 5 && c <= 8) || c == 14;
      exp_b = (c >= 6 && c <= 9);
      checks++; if (ext_gnt !== exp_g || cpu_stall !== exp_g)
        $display("FAIL burst_gnt c%0d: got gnt=%b stall=%b want %b", c, ext_gnt, cpu_stall, exp_g); else passes++;
      checks++; if (dbg_state !== exp_b) $display("FAIL burst_state c%0d: got %b want %b", c, dbg_state, exp_b); else passes++;
      checks++; if (mem_addr !== (exp_g ? 32'h20 + 32'(4 * k) : 32'h10) || mem_write !== exp_g)
        $display("FAIL burst_bus c%0d: got we=%b addr=%h", c, mem_write, mem_addr); else passes++;
      @(negedge clk);
      if (exp_g) begin
        k++;
        ext_addr = 32'h20 + 32'(4 * k);
        ext_wdata = 32'hA000_0000 + 32'(k);
      end
    end
    idle_inputs();
    @(negedge clk);
    cpu_mem_read = 1'b1; cpu_addr = 32'h28;
    #1;
    checks++; if (cpu_rdata !== 32'hA000_0002) $display("FAIL burst_mem28: got %h want a0000002", cpu_rdata); else passes++;
    @(negedge clk);
    cpu_addr = 32'h30;
    #1;
    checks++; if (cpu_rdata !== 32'hA000_0004) $display("FAIL burst_mem30: got %h want a0000004", cpu_rdata); else passes++;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    idle_inputs();
    ext_req = 1'b1; ext_lock = 1'b1; ext_addr = 32'h28;
    #1;
    checks++; if (ext_gnt !== 1'b1) $display("FAIL rstb_beat1: got %b want 1", ext_gnt); else passes++;
    @(negedge clk);
    ext_addr = 32'h2C;
    #1;
    checks++; if (ext_gnt !== 1'b1 || dbg_state !== 1'b1) $display("FAIL rstb_beat2: got %b/%b want 1/1", ext_gnt, dbg_state); else passes++;
    @(negedge clk);
    rst = 1'b0; cpu_mem_read = 1'b1; cpu_addr = 32'h10;
    #1;
    checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL rstb_in_reset: got gnt=%b stall=%b rd=%b want 0/0/0", ext_gnt, cpu_stall, mem_read); else passes++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dbg_state !== 1'b0 || dbg_starve_cnt !== '0 || ext_rvalid !== 1'b0)
      $display("FAIL rstb_after: got state=%b starve=%0d rvalid=%b want 0/0/0", dbg_state, dbg_starve_cnt, ext_rvalid); else passes++;
    checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) $display("FAIL rstb_after_gnt: got %b/%b want 0/0", ext_gnt, cpu_stall); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_req_drop();
    @(negedge clk);
    idle_inputs();
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b1; ext_addr = 32'h38; ext_wdata = 32'h5555;
    #1;
    checks++; if (ext_gnt !== 1'b1) $display("FAIL drop_beat1: got %b want 1", ext_gnt); else passes++;
    @(negedge clk);
    ext_req = 1'b0; cpu_mem_write = 1'b1; cpu_addr = 32'h3C; cpu_wdata = 32'h6666;
    #1;
    checks++; if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0 || dbg_state !== 1'b1)
      $display("FAIL drop_exit: got gnt=%b stall=%b state=%b want 0/0/1", ext_gnt, cpu_stall, dbg_state); else passes++;
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h3C) $display("FAIL drop_cpu_bus: got %b/%h want 1/3c", mem_write, mem_addr); else passes++;
    @(negedge clk);
    idle_inputs();
    cpu_mem_read = 1'b1; cpu_addr = 32'h38;
    #1;
    checks++; if (dbg_state !== 1'b0) $display("FAIL drop_arb: got %b want 0", dbg_state); else passes++;
    checks++; if (cpu_rdata !== 32'h5555) $display("FAIL drop_mem38: got %h want 5555", cpu_rdata); else passes++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    bit bursting = 1'b0;
    int beats = 0, streak = 0;
    bit cpu_act, g, exp_rvalid = 1'b0;
    logic exp_rd, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [W-1:0] exp_wd, exp_data;
    int sel;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = ram[i];
    exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      sel = $urandom_range(0, 2);
      cpu_mem_read = (sel == 1); cpu_mem_write = (sel == 2);
      cpu_addr = 32'($urandom_range(0, 15)) << 2; cpu_wdata = $urandom;
      ext_req = ($urandom_range(0, 3) != 0); ext_we = 1'($urandom_range(0, 1));
      ext_lock = ($urandom_range(0, 2) != 0);
      ext_addr = 32'($urandom_range(0, 15)) << 2; ext_wdata = $urandom;
      #1;
      cpu_act = cpu_mem_read | cpu_mem_write;
      if (!rst) g = 1'b0;
      else if (bursting) g = ext_req & ext_lock & (beats < MB);
      else g = ext_req & (!cpu_act || streak == MS);
      if (!rst) begin exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0; end
      else if (g) begin exp_rd = ~ext_we; exp_wr = ext_we; exp_addr = ext_addr; exp_wd = ext_wdata; end
      else begin exp_rd = cpu_mem_read; exp_wr = cpu_mem_write; exp_addr = cpu_addr; exp_wd = cpu_wdata; end
      checks++; if (ext_gnt !== g) $display("FAIL rnd_gnt n%0d: got %b want %b", n, ext_gnt, g); else passes++;
      checks++; if (cpu_stall !== (g & cpu_act)) $display("FAIL rnd_stall n%0d: got %b want %b", n, cpu_stall, g & cpu_act); else passes++;
      checks++; if (mem_read !== exp_rd || mem_write !== exp_wr)
        $display("FAIL rnd_rw n%0d: got %b%b want %b%b", n, mem_read, mem_write, exp_rd, exp_wr); else passes++;
      checks++; if (mem_addr !== exp_addr || mem_wdata !== exp_wd)
        $display("FAIL rnd_bus n%0d: got %h/%h want %h/%h", n, mem_addr, mem_wdata, exp_addr, exp_wd); else passes++;
      checks++; if (dbg_state !== bursting || dbg_starve_cnt !== SW'(streak))
        $display("FAIL rnd_state n%0d: got %b/%0d want %b/%0d", n, dbg_state, dbg_starve_cnt, bursting, streak); else passes++;
      checks++; if (ext_rvalid !== exp_rvalid) $display("FAIL rnd_rvalid n%0d: got %b want %b", n, ext_rvalid, exp_rvalid); else passes++;
      if (exp_rvalid && exp_q.size() > 0) begin
        exp_data = exp_q.pop_front();
        checks++; if (ext_rdata !== exp_data) $display("FAIL rnd_rdata n%0d: got %h want %h", n, ext_rdata, exp_data); else passes++;
      end
      if (rst && !g && cpu_mem_read) begin
        checks++; if (cpu_rdata !== ref_mem[cpu_addr[7:2]])
          $display("FAIL rnd_cpu_rdata n%0d: got %h want %h", n, cpu_rdata, ref_mem[cpu_addr[7:2]]); else passes++;
      end
      @(posedge clk);
      exp_rvalid = 1'b0;
      if (!rst) begin
        bursting = 1'b0; beats = 0; streak = 0;
        exp_q.delete();
      end else begin
        if (g && ext_we) ref_mem[ext_addr[7:2]] = ext_wdata;
        else if (g) begin exp_q.push_back(ref_mem[ext_addr[7:2]]); exp_rvalid = 1'b1; end
        else if (cpu_mem_write) ref_mem[cpu_addr[7:2]] = cpu_wdata;
        if (bursting) begin
          streak = 0;
          if (g) beats++;
          else begin bursting = 1'b0; beats = 0; end
        end else if (g) begin
          streak = 0;
          if (ext_lock) begin bursting = 1'b1; beats = 1; end
        end else begin
          streak = ext_req ? ((streak == MS) ? MS : streak + 1) : 0;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_cpu_alone();
    test_ext_idle_read();
    test_starvation();
    test_locked_burst();
    test_reset_mid_burst();
    test_req_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
